axis_sram_loader: RTL and testbench



---
 rtl/axis_sram_loader.sv | 195 +++++++++++++++++++
 tb/tb_axis_sram_loader.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_sram_loader.sv
// axis_sram_loader: unpacks int8 lanes of an AXI-Stream into per-segment
// SRAM writes. Metadata picks segment count and target SRAM per segment.
// Ports: s_axis_aclk/s_axis_aresetn clock and async low reset; init sync
// clear; meta_* load descriptor handshake; s_axis_* beat stream; wr_* SRAM
// write port (registered); seg_idx current segment; load_done end pulse;
// overflow_err sticky address overflow.
module axis_sram_loader #(
  parameter int AXIS_WIDTH = 32,
  parameter int ADDR_WIDTH = 13,
  parameter int MAX_SEGS   = 4,
  parameter int SEL_WIDTH  = 3,
  localparam int CNT_W  = $clog2(MAX_SEGS + 1),
  localparam int SEG_W  = (MAX_SEGS > 1) ? $clog2(MAX_SEGS) : 1,
  localparam int LANES  = AXIS_WIDTH / 8,
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                          s_axis_aclk,
  input  logic                          s_axis_aresetn,
  input  logic                          init,
  input  logic                          meta_valid,
  output logic                          meta_ready,
  input  logic [CNT_W-1:0]              meta_seg_count,
  input  logic [MAX_SEGS*SEL_WIDTH-1:0] meta_sram_sel,
  input  logic [AXIS_WIDTH-1:0]         s_axis_tdata,
  input  logic [LANES-1:0]              s_axis_tstrb,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  output logic                          wr_en,
  output logic [ADDR_WIDTH-1:0]         wr_addr,
  output logic [7:0]                    wr_data,
  output logic [SEL_WIDTH-1:0]          wr_sel,
  output logic [SEG_W-1:0]              seg_idx,
  output logic                          load_done,
  output logic                          overflow_err
);

  typedef enum logic [2:0] {
    IDLE,
    META,
    RECV,
    UNPACK,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [CNT_W-1:0]              cnt_q;
  logic [MAX_SEGS*SEL_WIDTH-1:0] sel_q;
  logic [AXIS_WIDTH-1:0]         tdata_q;
  logic [LANES-1:0]              strb_q;
  logic                          tlast_q;
  // One extra bit: reaching 2^ADDR_WIDTH marks the segment as overflowed.
  logic [ADDR_WIDTH:0]           addr_q;

  logic              meta_ok;
  logic              take_meta;
  logic              take_beat;
  logic              emit;
  logic              seg_next;
  logic              last_seg;
  logic [LANE_W-1:0] lane;
  logic [LANES-1:0]  rest;

  assign meta_ok = (meta_seg_count != '0) &&
                   (meta_seg_count <= CNT_W'(MAX_SEGS));
  assign last_seg = (CNT_W'(seg_idx) + CNT_W'(1)) == cnt_q;

  assign meta_ready    = (state_q == IDLE);
  assign s_axis_tready = (state_q == RECV);

  // Lowest pending lane; zero-strobe lanes never get a cycle.
  always_comb begin
    lane = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (strb_q[i]) lane = LANE_W'(i);
    end
  end

  assign rest = strb_q & ~(LANES'(1) << lane);

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) state_q <= IDLE;
    else                 state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    take_meta = 1'b0;
    take_beat = 1'b0;
    emit      = 1'b0;
    seg_next  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (meta_valid && meta_ok) begin
          take_meta = 1'b1;
          state_d   = META;
        end
      end
      META: state_d = RECV;
      RECV: begin
        if (s_axis_tvalid) begin
          take_beat = 1'b1;
          state_d   = UNPACK;
        end
      end
      UNPACK: begin
        emit = |strb_q;
        if (rest == '0) begin
          if (!tlast_q) begin
            state_d = RECV;
          end else if (last_seg) begin
            state_d = DONE;
          end else begin
            seg_next = 1'b1;
            state_d  = RECV;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (init) begin
      state_d   = IDLE;
      take_meta = 1'b0;
      take_beat = 1'b0;
      emit      = 1'b0;
      seg_next  = 1'b0;
    end
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      cnt_q        <= '0;
      sel_q        <= '0;
      tdata_q      <= '0;
      strb_q       <= '0;
      tlast_q      <= 1'b0;
      addr_q       <= '0;
      seg_idx      <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      wr_sel       <= '0;
      load_done    <= 1'b0;
      overflow_err <= 1'b0;
    end else if (init) begin
      cnt_q        <= '0;
      sel_q        <= '0;
      tdata_q      <= '0;
      strb_q       <= '0;
      tlast_q      <= 1'b0;
      addr_q       <= '0;
      seg_idx      <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      wr_sel       <= '0;
      load_done    <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      wr_en     <= 1'b0;
      load_done <= (state_q == DONE);
      if (take_meta) begin
        cnt_q   <= meta_seg_count;
        sel_q   <= meta_sram_sel;
        seg_idx <= '0;
        addr_q  <= '0;
      end
      if (take_beat) begin
        tdata_q <= s_axis_tdata;
        strb_q  <= s_axis_tstrb;
        tlast_q <= s_axis_tlast;
      end
      if (emit) begin
        strb_q  <= rest;
        wr_data <= tdata_q[lane*8 +: 8];
        wr_sel  <= sel_q[seg_idx*SEL_WIDTH +: SEL_WIDTH];
        if (addr_q[ADDR_WIDTH]) begin
          overflow_err <= 1'b1;
        end else begin
          wr_en   <= 1'b1;
          wr_addr <= addr_q[ADDR_WIDTH-1:0];
          addr_q  <= addr_q + (ADDR_WIDTH+1)'(1);
        end
      end
      if (seg_next) begin
        seg_idx <= seg_idx + SEG_W'(1);
        addr_q  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_axis_sram_loader.sv
// tb_axis_sram_loader: scoreboard bench for axis_sram_loader.
// Main instance uses defaults; a second with ADDR_WIDTH=2 shares inputs.
module tb_axis_sram_loader;

  logic        clk;
  logic        rst_n;
  logic        init;
  logic        meta_valid;
  logic        meta_ready;
  logic [2:0]  meta_seg_count;
  logic [11:0] meta_sram_sel;
  logic [31:0] s_axis_tdata;
  logic [3:0]  s_axis_tstrb;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic        wr_en;
  logic [12:0] wr_addr;
  logic [7:0]  wr_data;
  logic [2:0]  wr_sel;
  logic [1:0]  seg_idx;
  logic        load_done;
  logic        overflow_err;

  logic        sm_meta_ready;
  logic        sm_tready;
  logic        sm_wr_en;
  logic [1:0]  sm_wr_addr;
  logic [7:0]  sm_wr_data;
  logic [2:0]  sm_wr_sel;
  logic [1:0]  sm_seg_idx;
  logic        sm_load_done;
  logic        sm_overflow_err;

  axis_sram_loader u_dut (
    .s_axis_aclk    (clk),
    .s_axis_aresetn (rst_n),
    .init           (init),
    .meta_valid     (meta_valid),
    .meta_ready     (meta_ready),
    .meta_seg_count (meta_seg_count),
    .meta_sram_sel  (meta_sram_sel),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tstrb   (s_axis_tstrb),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tlast   (s_axis_tlast),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_sel         (wr_sel),
    .seg_idx        (seg_idx),
    .load_done      (load_done),
    .overflow_err   (overflow_err)
  );

  axis_sram_loader #(.ADDR_WIDTH(2)) u_sm (
    .s_axis_aclk    (clk),
    .s_axis_aresetn (rst_n),
    .init           (init),
    .meta_valid     (meta_valid),
    .meta_ready     (sm_meta_ready),
    .meta_seg_count (meta_seg_count),
    .meta_sram_sel  (meta_sram_sel),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tstrb   (s_axis_tstrb),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (sm_tready),
    .s_axis_tlast   (s_axis_tlast),
    .wr_en          (sm_wr_en),
    .wr_addr        (sm_wr_addr),
    .wr_data        (sm_wr_data),
    .wr_sel         (sm_wr_sel),
    .seg_idx        (sm_seg_idx),
    .load_done      (sm_load_done),
    .overflow_err   (sm_overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Scoreboard entries: {sel, addr, data}.
  logic [23:0] exp_q[$];
  logic [2:0]  bsel[4];
  int          bseg;
  logic [12:0] baddr;

  int wr_total    = 0;
  int last_wr_cyc = 0;
  int done_cnt    = 0;
  int done_cyc    = 0;
  int hs_cnt      = 0;
  int sm_wr_cnt   = 0;
  int sm_done_cnt = 0;

  always @(negedge clk) begin
    if (wr_en) begin
      wr_total++;
      last_wr_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_wr", {8'h0, wr_sel, wr_addr, wr_data}, 32'hFFFF_FFFF);
      end else begin
        check("wr_sel_addr_data", {8'h0, wr_sel, wr_addr, wr_data},
              {8'h0, exp_q.pop_front()});
      end
    end
    if (load_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (s_axis_tvalid && s_axis_tready) hs_cnt++;
    if (sm_wr_en) sm_wr_cnt++;
    if (sm_load_done) sm_done_cnt++;
  end

  task automatic send_meta(input logic [2:0] cnt, input logic [11:0] sel);
    int n = 0;
    meta_seg_count = cnt;
    meta_sram_sel  = sel;
    meta_valid     = 1'b1;
    while (!meta_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) check("meta_ready_timeout", {31'h0, meta_ready}, 1);
    @(posedge clk); #1;
    meta_valid = 1'b0;
    for (int k = 0; k < 4; k++) bsel[k] = sel[k*3 +: 3];
    bseg  = 0;
    baddr = '0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] s,
                           input logic l, input bit meas, output int busy);
    int n = 0;
    s_axis_tdata  = d;
    s_axis_tstrb  = s;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    busy = 0;
    while (!s_axis_tready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      check("tready_timeout", {31'h0, s_axis_tready}, 1);
      s_axis_tvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (s[i]) begin
        exp_q.push_back({bsel[bseg], baddr, d[i*8 +: 8]});
        baddr++;
      end
    end
    if (l) begin
      bseg++;
      baddr = '0;
    end
    if (meas) begin
      while (!s_axis_tready && busy < 20) begin
        @(posedge clk); #1;
        busy++;
      end
    end
  endtask

  task automatic wait_done(input int base, input bit lat);
    int n = 0;
    while (done_cnt == base && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("load_done_pulses", done_cnt - base, 1);
    if (lat) check("load_done_latency", done_cyc - last_wr_cyc, 1);
  endtask

  task automatic pulse_init();
    init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
  endtask

  typedef struct {
    logic [31:0] data;
    logic [3:0]  strb;
    int          busy;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int b;
    int base;
    int wbase;
    int hbase;
    int sbase;

    tbl[0] = '{32'hDDCCBBAA, 4'b0101, 2};
    tbl[1] = '{32'h11223344, 4'b1000, 1};
    tbl[2] = '{32'h55667788, 4'b0000, 1};
    tbl[3] = '{32'h99AABBCC, 4'b1111, 4};
    tbl[4] = '{32'h0A0B0C0D, 4'b0110, 2};

    rst_n = 1'b0;
    init = 1'b0;
    meta_valid = 1'b0;
    meta_seg_count = '0;
    meta_sram_sel = '0;
    s_axis_tdata = '0;
    s_axis_tstrb = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    bseg = 0;
    baddr = '0;
    for (int k = 0; k < 4; k++) bsel[k] = '0;

    #12;
    check("rst_meta_ready", {31'h0, meta_ready}, 1);
    check("rst_tready", {31'h0, s_axis_tready}, 0);
    check("rst_wr_en", {31'h0, wr_en}, 0);
    check("rst_wr_addr", {19'h0, wr_addr}, 0);
    check("rst_wr_data", {24'h0, wr_data}, 0);
    check("rst_wr_sel", {29'h0, wr_sel}, 0);
    check("rst_seg_idx", {30'h0, seg_idx}, 0);
    check("rst_load_done", {31'h0, load_done}, 0);
    check("rst_overflow", {31'h0, overflow_err}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic one-segment load.
    base = done_cnt;
    send_meta(3'd1, 12'o0002);
    check("meta_ready_busy", {31'h0, meta_ready}, 0);
    send_beat(32'h04030201, 4'hF, 1'b0, 1'b1, b);
    send_beat(32'h08070605, 4'hF, 1'b1, 1'b0, b);
    wait_done(base, 1'b1);

    // Strobe patterns, one table row per beat.
    base = done_cnt;
    send_meta(3'd1, 12'o0005);
    for (int i = 0; i < 5; i++) begin
      send_beat(tbl[i].data, tbl[i].strb, 1'b0, 1'b1, b);
      check($sformatf("busy_row%0d", i), b, tbl[i].busy);
    end
    send_beat(32'h0, 4'h0, 1'b1, 1'b0, b);
    wait_done(base, 1'b0);

    // Two segments with different SRAM selects.
    base = done_cnt;
    send_meta(3'd2, 12'o0041);
    send_beat(32'h13121110, 4'hF, 1'b0, 1'b0, b);
    send_beat(32'h17161514, 4'hF, 1'b1, 1'b1, b);
    check("seg_idx_adv", {30'h0, seg_idx}, 1);
    check("no_early_done", done_cnt - base, 0);
    send_beat(32'h23222120, 4'hF, 1'b0, 1'b0, b);
    send_beat(32'h27262524, 4'hF, 1'b1, 1'b0, b);
    wait_done(base, 1'b1);

    // Overflow on the narrow-address instance.
    pulse_init();
    check("init_clr_sm_ovf", {31'h0, sm_overflow_err}, 0);
    base  = done_cnt;
    wbase = sm_wr_cnt;
    sbase = sm_done_cnt;
    send_meta(3'd1, 12'o0003);
    send_beat(32'h04030201, 4'hF, 1'b0, 1'b0, b);
    send_beat(32'h00000605, 4'h3, 1'b1, 1'b0, b);
    wait_done(base, 1'b1);
    check("sm_wr_count", sm_wr_cnt - wbase, 4);
    check("sm_overflow", {31'h0, sm_overflow_err}, 1);
    check("sm_load_done", sm_done_cnt - sbase, 1);
    check("main_no_overflow", {31'h0, overflow_err}, 0);

    // init in the middle of unpacking.
    base = done_cnt;
    send_meta(3'd1, 12'o0006);
    s_axis_tdata  = 32'hAABBCCDD;
    s_axis_tstrb  = 4'hF;
    s_axis_tlast  = 1'b1;
    s_axis_tvalid = 1'b1;
    b = 0;
    while (!s_axis_tready && b < 100) begin
      @(posedge clk); #1;
      b++;
    end
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    exp_q.push_back({3'd6, 13'd0, 8'hDD});
    @(posedge clk); #1;
    init = 1'b1;
    @(posedge clk); #1;
    check("init_wr_en", {31'h0, wr_en}, 0);
    check("init_idle", {31'h0, meta_ready}, 1);
    check("init_tready", {31'h0, s_axis_tready}, 0);
    init = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("init_no_done", done_cnt - base, 0);
    base = done_cnt;
    send_meta(3'd1, 12'o0006);
    send_beat(32'h34333231, 4'hF, 1'b1, 1'b0, b);
    wait_done(base, 1'b1);

    // Invalid segment counts: no beats accepted.
    for (int r = 0; r < 2; r++) begin
      wbase = wr_total;
      hbase = hs_cnt;
      send_meta((r == 0) ? 3'd0 : 3'd5, 12'o7777);
      for (int c = 0; c < 24; c++) begin
        s_axis_tvalid = 1'($urandom_range(0, 1));
        s_axis_tdata  = $urandom;
        s_axis_tstrb  = 4'hF;
        s_axis_tlast  = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      s_axis_tvalid = 1'b0;
      @(posedge clk); #1;
      check($sformatf("bad_cnt_hs%0d", r), hs_cnt - hbase, 0);
      check($sformatf("bad_cnt_wr%0d", r), wr_total - wbase, 0);
      check($sformatf("bad_cnt_idle%0d", r), {31'h0, meta_ready}, 1);
    end

    check("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
